rf_wb_arbiter: RTL and testbench
================================

// Module: rf_wb_arbiter
// PURPOSE
//  - Shares the single regfile write port (we/waddr/wdata) between two writeback sources:
//    A = ALU/EX result and B = load/MEM result.
//  - Round-robin arbitration with a valid/ready handshake per source.
//  - Registered output stage drives the regfile write port; r0 writes are suppressed.
//  - Saturating stall counter for performance monitoring.
// PARAMETERS
//  - DATA_W  32  write data width
//  - ADDR_W  5   register address width (32 registers)
//  - CNT_W   16  stall counter width
// PORTS
//  - clk        in   1       clock, all state updates on posedge
//  - reset      in   1       synchronous, active-high reset
//  - a_valid    in   1       source A has a write pending
//  - a_ready    out  1       source A write accepted this cycle
//  - a_addr     in   ADDR_W  source A destination register
//  - a_data     in   DATA_W  source A write data
//  - b_valid    in   1       source B has a write pending
//  - b_ready    out  1       source B write accepted this cycle
//  - b_addr     in   ADDR_W  source B destination register
//  - b_data     in   DATA_W  source B write data
//  - rf_we      out  1       to regfile we
//  - rf_waddr   out  ADDR_W  to regfile waddr
//  - rf_wdata   out  DATA_W  to regfile wdata
//  - stall_cnt  out  CNT_W   cycles in which a valid source was not granted
// BEHAVIOUR
//  - Handshake: a transfer occurs when x_valid && x_ready at a posedge.
//    - x_ready is combinational from the valids and rr_ptr.
//    - Sources hold addr/data stable while valid && !ready.
//  - Grant rules (1-bit rr_ptr; 0 = A preferred):
//    - exactly one valid -> that source is granted; rr_ptr unchanged
//    - both valid -> grant the source at rr_ptr; rr_ptr toggles to the loser
//    - none valid -> no grant; rf_we=0 next cycle
//  - At most one ready is high per cycle.
//  - The output stage always drains, so a lone requester is never stalled.
//  - Latency:
//    - transfer at edge N -> rf_we=1 with that addr/data during cycle N+1
//    - the regfile commits at edge N+1
//    - two back-to-back transfers produce rf_we=1 on consecutive cycles
//  - r0 rule: a transfer with addr==0 completes the handshake, but rf_we=0 for that slot.
//  - rf_waddr and rf_wdata update on every transfer, including r0 transfers.
//  - When no transfer occurs, rf_waddr and rf_wdata hold their last value and rf_we=0.
//  - Same address on both sources in one cycle: the rr_ptr winner writes first, the loser
//    the next cycle. The final register value is the loser's data; no merging.
//  - stall_cnt: +1 each cycle with (a_valid && !a_ready) || (b_valid && !b_ready).
//    Saturates at all-ones; never wraps.
//  - Reset (applies at any time, including mid-burst):
//    - at the reset edge: rf_we=0, rf_waddr=0, rf_wdata=0, rr_ptr=0, stall_cnt=0
//    - a_ready=b_ready=0 while reset=1; pending source requests are not accepted
//    - a transfer presented in a cycle with reset=1 is discarded; sources must re-present
// CONFIGURATION
//  - Macro RF_WB_BYPASS_EN.
//  - Defined: adds ports fwd_raddr1/fwd_raddr2 (in, ADDR_W), fwd_hit1/fwd_hit2 (out, 1)
//    and fwd_data1/fwd_data2 (out, DATA_W).
//    - fwd_hitN = rf_we && (rf_waddr == fwd_raddrN) && (fwd_raddrN != 0)
//    - fwd_dataN = rf_wdata when hit, else 0
//    - purely combinational from the output stage, so decode sees a write in the same
//      cycle the regfile is written
//  - Undefined: these ports and their logic do not exist; all other behaviour is identical.
// TESTING
//  - Reset: hold reset with a_valid=1 -> a_ready=0; after release rf_we=0, stall_cnt=0.
//  - Lone A: a_valid=1, a_addr=5, a_data=32'h1234_5678 -> a_ready=1 same cycle; next
//    cycle rf_we=1, rf_waddr=5, rf_wdata=32'h1234_5678.
//  - Conflict: A(3, 32'hAAAA_AAAA) and B(3, 32'hBBBB_BBBB) held valid from reset ->
//    A granted cycle 0, B cycle 1; r3 ends as 32'hBBBB_BBBB; stall_cnt=1.
//  - Round-robin: both valid continuously for 6 cycles -> grants A,B,A,B,A,B;
//    stall_cnt=6.
//  - r0: b_valid=1, b_addr=0, b_data=32'hFFFF_FFFF -> b_ready=1; next cycle rf_we=0.
//  - Mid-burst reset and saturation: reset asserted while both are valid -> no rf_we the
//    next cycle, rr_ptr=0. With CNT_W forced to 4 and 20 conflict cycles -> stall_cnt=15.
//  - With RF_WB_BYPASS_EN: A(7, 32'hDEAD_BEEF) accepted, fwd_raddr1=7 next cycle ->
//    fwd_hit1=1, fwd_data1=32'hDEAD_BEEF; fwd_raddr2=0 -> fwd_hit2=0.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter
//
// Shares the single register-file write port between two writeback sources:
// A (ALU/EX result) and B (load/MEM result). A 1-bit round-robin pointer picks
// the winner when both request in the same cycle; the loser is served next.
// The accepted write is registered onto the regfile port one cycle later.
// Writes to r0 complete the handshake but are never enabled at the regfile.
// A saturating counter tracks cycles in which a valid source was held off.
//
// Optional feature (macro RF_WB_BYPASS_EN): two combinational forwarding
// lookups against the output stage so decode can see an in-flight write in
// the same cycle the regfile commits it.
//
// Ports
//   clk, reset                 clock; synchronous active-high reset
//   a_valid/a_ready/a_addr/a_data   source A handshake and payload
//   b_valid/b_ready/b_addr/b_data   source B handshake and payload
//   rf_we/rf_waddr/rf_wdata    registered regfile write port
//   stall_cnt                  saturating count of stalled-request cycles
//   fwd_raddr1/2, fwd_hit1/2, fwd_data1/2   (RF_WB_BYPASS_EN only)
// -----------------------------------------------------------------------------
module rf_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
`ifdef RF_WB_BYPASS_EN
    input  logic [ADDR_W-1:0] fwd_raddr1,
    input  logic [ADDR_W-1:0] fwd_raddr2,
    output logic              fwd_hit1,
    output logic              fwd_hit2,
    output logic [DATA_W-1:0] fwd_data1,
    output logic [DATA_W-1:0] fwd_data2,
`endif
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [CNT_W-1:0]  stall_cnt
);

    // 0 = A preferred on conflict, 1 = B preferred.
    logic rr_ptr;
    logic stalled;

    // Grant logic. The output stage always drains, so a lone requester is
    // granted unconditionally; rr_ptr only matters when both are valid.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (!reset) begin
            if (a_valid && b_valid) begin
                a_ready = !rr_ptr;
                b_ready = rr_ptr;
            end else begin
                a_ready = a_valid;
                b_ready = b_valid;
            end
        end
    end

    assign stalled = (a_valid && !a_ready) || (b_valid && !b_ready);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            rr_ptr    <= 1'b0;
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            stall_cnt <= '0;
        end else begin
            // On conflict the pointer moves to the loser so it wins next time.
            if (a_valid && b_valid)
                rr_ptr <= ~rr_ptr;

            // Address/data follow every transfer, r0 included; only the
            // enable is suppressed for r0.
            if (a_ready) begin
                rf_we    <= (a_addr != '0);
                rf_waddr <= a_addr;
                rf_wdata <= a_data;
            end else if (b_ready) begin
                rf_we    <= (b_addr != '0);
                rf_waddr <= b_addr;
                rf_wdata <= b_data;
            end else begin
                rf_we    <= 1'b0;
            end

            if (stalled && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

`ifdef RF_WB_BYPASS_EN
    // Reads of r0 never hit: r0 is hardwired and is never written anyway.
    assign fwd_hit1  = rf_we && (rf_waddr == fwd_raddr1) && (fwd_raddr1 != '0);
    assign fwd_hit2  = rf_we && (rf_waddr == fwd_raddr2) && (fwd_raddr2 != '0);
    assign fwd_data1 = fwd_hit1 ? rf_wdata : '0;
    assign fwd_data2 = fwd_hit2 ? rf_wdata : '0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_wb_arbiter
//
// Directed bench for rf_wb_arbiter. Each step drives both sources, checks the
// combinational readies, pushes the write expected on the regfile port into a
// queue, and after the clock edge pops and compares it against the DUT.
// A second instance with a 4-bit stall counter shares the stimulus and is used
// to check counter saturation.
// -----------------------------------------------------------------------------
module tb_rf_wb_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              a_valid, b_valid;
    logic [ADDR_W-1:0] a_addr, b_addr;
    logic [DATA_W-1:0] a_data, b_data;
    logic              a_ready, b_ready;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [15:0]       stall_cnt;

    logic              a_ready4, b_ready4, rf_we4;
    logic [ADDR_W-1:0] rf_waddr4;
    logic [DATA_W-1:0] rf_wdata4;
    logic [3:0]        stall_cnt4;

`ifdef RF_WB_BYPASS_EN
    logic [ADDR_W-1:0] fwd_raddr1, fwd_raddr2;
    logic              fwd_hit1, fwd_hit2, fwd_hit1_4, fwd_hit2_4;
    logic [DATA_W-1:0] fwd_data1, fwd_data2, fwd_data1_4, fwd_data2_4;
`endif

    always #5 clk = ~clk;

    rf_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
`ifdef RF_WB_BYPASS_EN
        .fwd_raddr1(fwd_raddr1), .fwd_raddr2(fwd_raddr2),
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
`endif
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .stall_cnt(stall_cnt)
    );

    rf_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready4), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready4), .b_addr(b_addr), .b_data(b_data),
`ifdef RF_WB_BYPASS_EN
        .fwd_raddr1(fwd_raddr1), .fwd_raddr2(fwd_raddr2),
        .fwd_hit1(fwd_hit1_4), .fwd_hit2(fwd_hit2_4),
        .fwd_data1(fwd_data1_4), .fwd_data2(fwd_data2_4),
`endif
        .rf_we(rf_we4), .rf_waddr(rf_waddr4), .rf_wdata(rf_wdata4),
        .stall_cnt(stall_cnt4)
    );

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t               exp_q[$];
    logic [ADDR_W-1:0] last_addr;
    logic [DATA_W-1:0] last_data;
    logic [DATA_W-1:0] regs [32];

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock of stimulus: drive, check readies, push expected write,
    // clock, then pop and compare the regfile port.
    task automatic step(input string tag,
                        input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                        input logic bv, input logic [ADDR_W-1:0] ba, input logic [DATA_W-1:0] bd,
                        input logic exp_ar, input logic exp_br);
        wr_t e, got;
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        #1;
        check({tag, ".a_ready"}, a_ready, exp_ar);
        check({tag, ".b_ready"}, b_ready, exp_br);
        if (exp_ar)      begin e.we = (aa != 0); e.addr = aa; e.data = ad; end
        else if (exp_br) begin e.we = (ba != 0); e.addr = ba; e.data = bd; end
        else             begin e.we = 1'b0; e.addr = last_addr; e.data = last_data; end
        last_addr = e.addr;
        last_data = e.data;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        check({tag, ".rf_we"},    rf_we,    got.we);
        check({tag, ".rf_waddr"}, rf_waddr, got.addr);
        check({tag, ".rf_wdata"}, rf_wdata, got.data);
        if (rf_we) regs[rf_waddr] = rf_wdata;
    endtask

    // Reset cycle with the given valids held: no ready, outputs cleared.
    task automatic do_reset(input string tag, input logic av, input logic bv);
        reset = 1'b1;
        a_valid = av; a_addr = 5'd9;  a_data = 32'h0101_0101;
        b_valid = bv; b_addr = 5'd10; b_data = 32'h0202_0202;
        #1;
        check({tag, ".a_ready"}, a_ready, 1'b0);
        check({tag, ".b_ready"}, b_ready, 1'b0);
        @(posedge clk);
        #1;
        check({tag, ".rf_we"},     rf_we,     1'b0);
        check({tag, ".rf_waddr"},  rf_waddr,  '0);
        check({tag, ".rf_wdata"},  rf_wdata,  '0);
        check({tag, ".stall_cnt"}, stall_cnt, '0);
        reset = 1'b0;
        exp_q.delete();
        last_addr = '0;
        last_data = '0;
    endtask

    initial begin
        reset = 1'b1;
        a_valid = 0; b_valid = 0;
        a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
`ifdef RF_WB_BYPASS_EN
        fwd_raddr1 = '0; fwd_raddr2 = '0;
`endif
        for (int i = 0; i < 32; i++) regs[i] = '0;

        // Reset held with A pending.
        do_reset("reset", 1'b1, 1'b0);
        step("idle0", 0, 0, 0, 0, 0, 0, 0, 0);
        check("idle0.stall_cnt", stall_cnt, 16'd0);

        // Lone A.
        step("loneA", 1, 5'd5, 32'h1234_5678, 0, 0, 0, 1, 0);
        check("loneA.stall_cnt", stall_cnt, 16'd0);

        // r0 write from B: handshake completes, no enable, addr/data still update.
        step("r0", 0, 0, 0, 1, 5'd0, 32'hFFFF_FFFF, 0, 1);
        step("hold", 0, 0, 0, 0, 0, 0, 0, 0);

        // Same-address conflict from reset.
        do_reset("rst_conf", 1'b1, 1'b1);
        step("conf0", 1, 5'd3, 32'hAAAA_AAAA, 1, 5'd3, 32'hBBBB_BBBB, 1, 0);
        step("conf1", 0, 0, 0, 1, 5'd3, 32'hBBBB_BBBB, 0, 1);
        check("conf.r3", regs[3], 32'hBBBB_BBBB);
        check("conf.stall_cnt", stall_cnt, 16'd1);

        // Round-robin: both valid for 6 cycles -> A,B,A,B,A,B.
        do_reset("rst_rr", 1'b0, 1'b0);
        for (int i = 0; i < 6; i++)
            step($sformatf("rr%0d", i),
                 1, 5'(10 + i), 32'hA000_0000 + i,
                 1, 5'(20 + i), 32'hB000_0000 + i,
                 (i % 2) == 0, (i % 2) == 1);
        check("rr.stall_cnt", stall_cnt, 16'd6);

        // Mid-burst reset: pointer is on B after one conflict, reset returns it to A.
        step("mid0", 1, 5'd1, 32'h1111_1111, 1, 5'd2, 32'h2222_2222, 1, 0);
        do_reset("mid_rst", 1'b1, 1'b1);
        step("mid1", 1, 5'd1, 32'h1111_1111, 1, 5'd2, 32'h2222_2222, 1, 0);

        // Saturation: 20 conflict cycles on the 4-bit counter instance.
        do_reset("rst_sat", 1'b0, 1'b0);
        for (int i = 0; i < 20; i++)
            step($sformatf("sat%0d", i),
                 1, 5'd4, 32'hC000_0000 + i,
                 1, 5'd6, 32'hD000_0000 + i,
                 (i % 2) == 0, (i % 2) == 1);
        check("sat.stall_cnt4", stall_cnt4, 4'hF);
        check("sat.stall_cnt16", stall_cnt, 16'd20);

`ifdef RF_WB_BYPASS_EN
        // Forwarding from the output stage in the write cycle.
        do_reset("rst_fwd", 1'b0, 1'b0);
        step("fwdA", 1, 5'd7, 32'hDEAD_BEEF, 0, 0, 0, 1, 0);
        fwd_raddr1 = 5'd7;
        fwd_raddr2 = 5'd0;
        #1;
        check("fwd.hit1",  fwd_hit1,  1'b1);
        check("fwd.data1", fwd_data1, 32'hDEAD_BEEF);
        check("fwd.hit2",  fwd_hit2,  1'b0);
        check("fwd.data2", fwd_data2, 32'h0);
        fwd_raddr1 = 5'd8;
        #1;
        check("fwd.miss1", fwd_hit1,  1'b0);
        check("fwd.miss1d", fwd_data1, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
